// File: rtl/fu_mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency data RAM port between the integer and FPU
// load/store paths. One access is in flight at a time, and a one-cycle done pulse ends it.
module fu_mem_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [2:0]    req0_bhw,
  input  logic [AW-1:0] req0_rs1,
  input  logic [AW-1:0] req0_imm,
  input  logic [AW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_done,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [2:0]    req1_bhw,
  input  logic [AW-1:0] req1_rs1,
  input  logic [AW-1:0] req1_imm,
  input  logic [AW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_done,
  output logic [AW-1:0] resp_rdata,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [AW-1:0] ram_wdata,
  output logic          ram_we,
  output logic [2:0]    ram_bhw,
  input  logic [AW-1:0] ram_rdata
);
  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wdata_q, wdata_d;
  logic [2:0]      bhw_q, bhw_d;
  logic [AW-1:0]   rdata_q, rdata_d;
  logic            grant;
  logic            accept;

  // A lone requester always wins; with both valid, the one not served last wins.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign accept = (state_q == StIdle) && (req0_valid || req1_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bhw_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bhw_q        <= bhw_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bhw_d        = bhw_q;
    rdata_d      = rdata_q;
    if (accept) begin
      last_grant_d = grant;
      owner_d      = grant;
      we_d         = grant ? req1_we : req0_we;
      addr_d       = grant ? (req1_rs1 + req1_imm) : (req0_rs1 + req0_imm);
      wdata_d      = grant ? req1_wdata : req0_wdata;
      bhw_d        = grant ? req1_bhw : req0_bhw;
    end
    // Stores leave the previous response untouched.
    if ((state_q == StAccess) && (cnt_q == CntLast) && !we_q) begin
      rdata_d = ram_rdata;
    end
  end

  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    req0_done  = (state_q == StDone) && !owner_q;
    req1_done  = (state_q == StDone) && owner_q;
    busy       = (state_q != StIdle);
    ram_we     = (state_q == StAccess) && (cnt_q == '0) && we_q;
    ram_addr   = addr_q;
    ram_wdata  = wdata_q;
    ram_bhw    = bhw_q;
    resp_rdata = rdata_q;
  end

endmodule

// File: tb/tb_fu_mem_arbiter.sv
// Bench for fu_mem_arbiter: directed vector table, hand-written multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_fu_mem_arbiter;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;
  localparam int          Lat = LAT;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_we, req0_ready, req0_done;
  logic [2:0]    req0_bhw;
  logic [AW-1:0] req0_rs1, req0_imm, req0_wdata;
  logic          req1_valid, req1_we, req1_ready, req1_done;
  logic [2:0]    req1_bhw;
  logic [AW-1:0] req1_rs1, req1_imm, req1_wdata;
  logic [AW-1:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic          busy, ram_we;
  logic [2:0]    ram_bhw;

  fu_mem_arbiter #(.LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_bhw(req0_bhw), .req0_rs1(req0_rs1),
    .req0_imm(req0_imm), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_bhw(req1_bhw), .req1_rs1(req1_rs1),
    .req1_imm(req1_imm), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_done(req1_done),
    .resp_rdata(resp_rdata), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_bhw(ram_bhw), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] prev_resp;

  typedef struct {
    logic        v0, v1, we;
    logic [2:0]  bhw;
    logic [31:0] rs1, imm0, imm1, wd0, wd1, rdata;
    logic        win;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_bhw = '0; req0_rs1 = '0; req0_imm = '0;
    req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_bhw = '0; req1_rs1 = '0; req1_imm = '0;
    req1_wdata = '0;
    ram_rdata = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, DUT idle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    prev_resp = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int we_cnt = 0;
    req0_valid = v.v0; req0_we = v.we; req0_bhw = v.bhw; req0_rs1 = v.rs1;
    req0_imm = v.imm0; req0_wdata = v.wd0;
    req1_valid = v.v1; req1_we = v.we; req1_bhw = v.bhw; req1_rs1 = v.rs1;
    req1_imm = v.imm1; req1_wdata = v.wd1;
    ram_rdata = v.rdata;
    #1;
    check($sformatf("v%0d_ready", idx), 32'({req1_ready, req0_ready}),
          v.win ? 32'd2 : 32'd1);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    check($sformatf("v%0d_addr", idx), ram_addr, v.exp_addr);
    check($sformatf("v%0d_wdata", idx), ram_wdata, v.exp_wdata);
    check($sformatf("v%0d_bhw", idx), 32'(ram_bhw), 32'(v.bhw));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    for (int k = 0; k <= Lat; k++) begin
      if (ram_we) we_cnt++;
      if (k < Lat) begin
        check($sformatf("v%0d_early_done", idx), 32'({req1_done, req0_done}), 32'd0);
      end else begin
        check($sformatf("v%0d_done", idx), 32'({req1_done, req0_done}),
              v.win ? 32'd2 : 32'd1);
        if (!v.we) prev_resp = v.rdata;
        check($sformatf("v%0d_resp", idx), resp_rdata, prev_resp);
        check($sformatf("v%0d_addr_hold", idx), ram_addr, v.exp_addr);
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("v%0d_we_count", idx), 32'(we_cnt), 32'(v.we));
    check($sformatf("v%0d_idle", idx), 32'({busy, req1_done, req0_done}), 32'd0);
  endtask

  // Reference model: a transaction either idle (age -1) or aged 0..LAT since accept.
  int          m_age;
  logic        m_last, m_owner, m_we;
  logic [31:0] m_addr, m_wdata, m_resp;
  logic [2:0]  m_bhw;

  task automatic model_reset();
    m_age = -1; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_resp = '0; m_bhw = '0;
  endtask

  initial begin
    int order[$];
    int acc_cyc[$];
    int rem0, rem1, d0, d1, got, first_c, second_c;
    logic last_win;
    logic e_r0, e_r1;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h8, 32'h0, 32'h0, 32'h0,
                32'hDEADBEEF, 1'b0, 32'h108, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h12345678,
                32'h0, 1'b1, 32'h1FC, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 3'b000, 32'hFFFFFFF0, 32'h20, 32'h30, 32'h0, 32'h0,
                32'hA5A5A5A5, 1'b0, 32'h10, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h4, 32'h4, 32'h8, 32'h11, 32'h22,
                32'h0BADF00D, 1'b1, 32'hC, 32'h22};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 3'b001, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE,
                32'h0, 1'b1, 32'h0, 32'hCAFE};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h10, 32'h20, 32'hAA, 32'hBB,
                32'h0, 1'b0, 32'h20, 32'hAA};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h80000000, 32'h80000000, 32'h0, 32'h5, 32'h0,
                32'h13579BDF, 1'b0, 32'h0, 32'h5};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h1, 32'h3, 32'h0, 32'h0,
                32'h2468ACE0, 1'b1, 32'h1003, 32'h0};

    rst = 1'b1;
    do_reset();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_done", 32'({req1_done, req0_done}), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_bhw", 32'(ram_bhw), 32'd0);
    check("rst_resp", resp_rdata, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Contention: both hold valid for three requests each.
    do_reset();
    rem0 = 3; rem1 = 3; d0 = 0; d1 = 0; last_win = 1'b0;
    req0_valid = 1'b1; req0_rs1 = 32'h400;
    req1_valid = 1'b1; req1_rs1 = 32'h800;
    for (int cyc = 0; cyc < 80 && (d0 + d1) < 6; cyc++) begin
      #1;
      check("dual_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_done || req1_done) begin
        check("done_owner", 32'({req1_done, req0_done}), last_win ? 32'd2 : 32'd1);
        if (req0_done) d0++;
        if (req1_done) d1++;
      end
      if (req0_ready) begin order.push_back(0); acc_cyc.push_back(cyc); last_win = 1'b0; rem0--; end
      if (req1_ready) begin order.push_back(1); acc_cyc.push_back(cyc); last_win = 1'b1; rem1--; end
      @(posedge clk);
      #1;
      if (rem0 <= 0) req0_valid = 1'b0;
      if (rem1 <= 0) req1_valid = 1'b0;
    end
    check("grant_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) check("grant_order", 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < acc_cyc.size(); i++)
      check("accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(Lat + 2));
    check("done0_count", 32'(d0), 32'd3);
    check("done1_count", 32'(d1), 32'd3);

    // Back-to-back from one requester, payload changed after the first accept.
    do_reset();
    got = 0; first_c = 0; second_c = 0;
    req0_valid = 1'b1; req0_rs1 = 32'h300; req0_imm = 32'h0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      #1;
      if (req0_ready) begin
        if (got == 0) first_c = cyc; else second_c = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      if (got == 1) req0_imm = 32'h4;
      if (got == 2) req0_valid = 1'b0;
    end
    check("b2b_count", 32'(got), 32'd2);
    check("b2b_spacing", 32'(second_c - first_c), 32'(Lat + 2));
    check("b2b_addr", ram_addr, 32'h304);
    repeat (Lat + 2) @(posedge clk);
    #1;

    // Reset in the second ACCESS cycle of a requester-1 load.
    do_reset();
    req1_valid = 1'b1; req1_rs1 = 32'h40; ram_rdata = 32'h55AA55AA;
    #1 check("mid_ready1", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_addr_after", ram_addr, 32'd0);
    for (int k = 0; k < Lat + 2; k++) begin
      check("mid_no_done", 32'({req1_done, req0_done}), 32'd0);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("mid_regrant", 32'({req1_ready, req0_ready}), 32'd1);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (Lat + 2) @(posedge clk);
    #1;

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_we = $urandom_range(0, 1) != 0; req1_we = $urandom_range(0, 1) != 0;
      req0_bhw = 3'($urandom); req1_bhw = 3'($urandom);
      req0_rs1 = $urandom; req0_imm = $urandom; req0_wdata = $urandom;
      req1_rs1 = $urandom; req1_imm = $urandom; req1_wdata = $urandom;
      ram_rdata = $urandom;
      #1;
      e_r0 = (m_age < 0) && req0_valid && (!req1_valid || m_last);
      e_r1 = (m_age < 0) && req1_valid && (!req0_valid || !m_last);
      check("rnd_ready0", 32'(req0_ready), 32'(e_r0));
      check("rnd_ready1", 32'(req1_ready), 32'(e_r1));
      check("rnd_done0", 32'(req0_done), 32'((m_age == Lat) && !m_owner));
      check("rnd_done1", 32'(req1_done), 32'((m_age == Lat) && m_owner));
      check("rnd_busy", 32'(busy), 32'(m_age >= 0));
      check("rnd_we", 32'(ram_we), 32'((m_age == 0) && m_we));
      check("rnd_addr", ram_addr, m_addr);
      check("rnd_wdata", ram_wdata, m_wdata);
      check("rnd_bhw", 32'(ram_bhw), 32'(m_bhw));
      check("rnd_resp", resp_rdata, m_resp);
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else if (e_r0 || e_r1) begin
        m_age = 0; m_last = e_r1; m_owner = e_r1;
        m_we    = e_r1 ? req1_we : req0_we;
        m_addr  = e_r1 ? req1_rs1 + req1_imm : req0_rs1 + req0_imm;
        m_wdata = e_r1 ? req1_wdata : req0_wdata;
        m_bhw   = e_r1 ? req1_bhw : req0_bhw;
      end else if (m_age >= 0) begin
        if (m_age == Lat - 1 && !m_we) m_resp = ram_rdata;
        m_age = (m_age == Lat) ? -1 : m_age + 1;
      end
      #1;
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
